// File: rtl/div_issue.sv
// EX-stage initiator for the iterative divider.
// It takes a DIV/DIVU request, drives the divider's start/annul/operand
// handshake, stalls the pipeline while the divide runs, and returns the
// quotient and remainder as a single-cycle HI/LO write.
//
//   state   | meaning
//   --------+-----------------------------------------------------------
//   IDLE    | no divide in flight; accepts a request that is not flushed
//   WAIT    | divider running; operands held stable, busy counter counts
//   RELEASE | result captured; waits for the divider to drop ready
//   FLUSH   | divide cancelled; annul held until the divider has drained
module div_issue #(
  parameter int unsigned TIMEOUT = 64,
  parameter int unsigned DRAIN   = 3
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        req_i,
  input  logic        signed_i,
  input  logic [31:0] opdata1_i,
  input  logic [31:0] opdata2_i,
  input  logic        flush_i,
  input  logic [63:0] div_result_i,
  input  logic        div_ready_i,
  output logic        signed_div_o,
  output logic [31:0] div_opdata1_o,
  output logic [31:0] div_opdata2_o,
  output logic        div_start_o,
  output logic        div_annul_o,
  output logic        stallreq_o,
  output logic        whilo_o,
  output logic [31:0] hi_o,
  output logic [31:0] lo_o,
  output logic        err_o
);

  localparam int unsigned CW = $clog2(TIMEOUT + 1);
  localparam int unsigned DW = (DRAIN > 1) ? $clog2(DRAIN) : 1;

  typedef enum logic [1:0] {
    S_IDLE,
    S_WAIT,
    S_RELEASE,
    S_FLUSH
  } state_t;

  state_t        state_q, state_d;
  logic          start_q, start_d;
  logic          annul_q, annul_d;
  logic          signed_q, signed_d;
  logic [31:0]   op1_q, op1_d;
  logic [31:0]   op2_q, op2_d;
  logic          whilo_q, whilo_d;
  logic [31:0]   hi_q, hi_d;
  logic [31:0]   lo_q, lo_d;
  logic          err_q, err_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic [DW-1:0] drain_q, drain_d;
  logic          stall;

  // State and handshake registers; the divider shares this reset, so a
  // mid-operation reset needs no drain.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= S_IDLE;
      start_q  <= 1'b0;
      annul_q  <= 1'b0;
      signed_q <= 1'b0;
      op1_q    <= '0;
      op2_q    <= '0;
      whilo_q  <= 1'b0;
      hi_q     <= '0;
      lo_q     <= '0;
      err_q    <= 1'b0;
      cnt_q    <= '0;
      drain_q  <= '0;
    end else begin
      state_q  <= state_d;
      start_q  <= start_d;
      annul_q  <= annul_d;
      signed_q <= signed_d;
      op1_q    <= op1_d;
      op2_q    <= op2_d;
      whilo_q  <= whilo_d;
      hi_q     <= hi_d;
      lo_q     <= lo_d;
      err_q    <= err_d;
      cnt_q    <= cnt_d;
      drain_q  <= drain_d;
    end
  end

  // Next-state logic; flush beats ready, ready beats the timeout.
  always_comb begin
    state_d  = state_q;
    start_d  = start_q;
    annul_d  = annul_q;
    signed_d = signed_q;
    op1_d    = op1_q;
    op2_d    = op2_q;
    whilo_d  = 1'b0;
    hi_d     = hi_q;
    lo_d     = lo_q;
    err_d    = err_q;
    cnt_d    = cnt_q;
    drain_d  = drain_q;

    case (state_q)
      S_IDLE: begin
        if (req_i && !flush_i) begin
          signed_d = signed_i;
          op1_d    = opdata1_i;
          op2_d    = opdata2_i;
          start_d  = 1'b1;
          cnt_d    = '0;
          state_d  = S_WAIT;
        end
      end
      S_WAIT: begin
        cnt_d = cnt_q + CW'(1);
        if (flush_i) begin
          start_d = 1'b0;
          annul_d = 1'b1;
          drain_d = DW'(DRAIN - 1);
          state_d = S_FLUSH;
        end else if (div_ready_i) begin
          hi_d    = div_result_i[63:32];
          lo_d    = div_result_i[31:0];
          whilo_d = 1'b1;
          start_d = 1'b0;
          state_d = S_RELEASE;
        end else if (cnt_q == CW'(TIMEOUT - 1)) begin
          // The divider has hung: flag it and abandon the request through
          // the same drain path a pipeline flush uses.
          err_d   = 1'b1;
          start_d = 1'b0;
          annul_d = 1'b1;
          drain_d = DW'(DRAIN - 1);
          state_d = S_FLUSH;
        end
      end
      S_RELEASE: begin
        start_d = 1'b0;
        if (!div_ready_i) begin
          state_d = S_IDLE;
        end
      end
      S_FLUSH: begin
        start_d = 1'b0;
        if (flush_i) begin
          drain_d = DW'(DRAIN - 1);
        end else if (drain_q == '0) begin
          annul_d = 1'b0;
          state_d = S_IDLE;
        end else begin
          drain_d = drain_q - DW'(1);
        end
      end
      default: begin
        state_d = S_IDLE;
        start_d = 1'b0;
        annul_d = 1'b0;
      end
    endcase
  end

  // Stall request; dropped in the HI/LO write cycle so the pipeline
  // advances exactly when the result lands, and whenever flush is active.
  always_comb begin
    stall = 1'b0;
    if (!flush_i && !whilo_q) begin
      case (state_q)
        S_WAIT:  stall = 1'b1;
        default: stall = req_i;
      endcase
    end
  end

  assign signed_div_o  = signed_q;
  assign div_opdata1_o = op1_q;
  assign div_opdata2_o = op2_q;
  assign div_start_o   = start_q;
  assign div_annul_o   = annul_q;
  assign stallreq_o    = stall;
  assign whilo_o       = whilo_q;
  assign hi_o          = hi_q;
  assign lo_o          = lo_q;
  assign err_o         = err_q;

endmodule
